// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined hierarchical CLA adder.
// Holds the group width and the skid-buffer state encoding.
package adder_pkg;

    localparam int GROUP_W = 4;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_e;

endpackage

// File: rtl/pg_group_4bit.sv
// Bit-level and 4-bit group propagate/generate for one nibble of the operands.
// Purely combinational; carries are resolved downstream.
module pg_group_4bit
    import adder_pkg::*;
(
    input  logic [GROUP_W-1:0] a,
    input  logic [GROUP_W-1:0] b,
    output logic [GROUP_W-1:0] p,
    output logic [GROUP_W-1:0] g,
    output logic               gp,
    output logic               gg
);

    assign p  = a ^ b;
    assign g  = a & b;
    assign gp = &p;
    // Group generates a carry-out regardless of its carry-in.
    assign gg = g[3]
              | (p[3] & g[2])
              | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]);

endmodule

// File: rtl/cla_pg_pipe_stage.sv
// Registered P/G input stage of the pipelined CLA adder.
// A 2-entry skid buffer (main M, skid S) keeps in_ready_o a pure flop output.
module cla_pg_pipe_stage
    import adder_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic [WIDTH-1:0]          a_i,
    input  logic [WIDTH-1:0]          b_i,
    input  logic                      cin_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [WIDTH-1:0]          propagate_o,
    output logic [WIDTH-1:0]          generate_o,
    output logic [WIDTH/GROUP_W-1:0]  group_propagate_o,
    output logic [WIDTH/GROUP_W-1:0]  group_generate_o,
    output logic                      cin_o
);

    localparam int N_GROUPS = WIDTH / GROUP_W;

    if (WIDTH % GROUP_W != 0) begin : g_width_check
        $error("cla_pg_pipe_stage: WIDTH must be a multiple of 4");
    end

    typedef struct packed {
        logic [WIDTH-1:0]    p;
        logic [WIDTH-1:0]    g;
        logic [N_GROUPS-1:0] gp;
        logic [N_GROUPS-1:0] gg;
        logic                cin;
    } pg_word_t;

    logic [WIDTH-1:0]    p_comb;
    logic [WIDTH-1:0]    g_comb;
    logic [N_GROUPS-1:0] gp_comb;
    logic [N_GROUPS-1:0] gg_comb;
    pg_word_t            in_word;

    for (genvar k = 0; k < N_GROUPS; k++) begin : g_group
        pg_group_4bit u_group (
            .a  (a_i[k*GROUP_W +: GROUP_W]),
            .b  (b_i[k*GROUP_W +: GROUP_W]),
            .p  (p_comb[k*GROUP_W +: GROUP_W]),
            .g  (g_comb[k*GROUP_W +: GROUP_W]),
            .gp (gp_comb[k]),
            .gg (gg_comb[k])
        );
    end

    assign in_word = '{p: p_comb, g: g_comb, gp: gp_comb, gg: gg_comb, cin: cin_i};

    skid_state_e state_q;
    skid_state_e state_d;
    logic        in_ready_q;
    logic        out_valid;
    logic        accept;
    logic        deliver;
    logic        load_m_in;
    logic        load_m_s;
    logic        load_s;
    pg_word_t    m_q;
    pg_word_t    s_q;

    assign accept  = in_valid_i & in_ready_q;
    assign deliver = out_valid & out_ready_i;

    // State register; ready is precomputed from the next state so it leaves a flop.
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != TWO);
        end
    end

    // NOTE: every always_comb output gets a default first, so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        load_m_in = 1'b0;
        load_m_s  = 1'b0;
        load_s    = 1'b0;
        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d   = ONE;
                    load_m_in = 1'b1;
                end
            end
            ONE: begin
                if (accept && !deliver) begin
                    state_d = TWO;
                    load_s  = 1'b1;
                end else if (accept && deliver) begin
                    load_m_in = 1'b1;
                end else if (deliver) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (deliver) begin
                    state_d  = ONE;
                    load_m_s = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_comb begin
        out_valid   = (state_q != EMPTY);
        out_valid_o = out_valid;
        in_ready_o  = in_ready_q;
    end

    // NOTE: the two data registers are cleared on reset so the outputs read 0, not stale words.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            m_q <= '0;
            s_q <= '0;
        end else begin
            if (load_m_in) begin
                m_q <= in_word;
            end else if (load_m_s) begin
                m_q <= s_q;
            end
            if (load_s) begin
                s_q <= in_word;
            end
        end
    end

    assign propagate_o       = m_q.p;
    assign generate_o        = m_q.g;
    assign group_propagate_o = m_q.gp;
    assign group_generate_o  = m_q.gg;
    assign cin_o             = m_q.cin;

endmodule

// File: tb/tb_cla_pg_pipe_stage.sv
// Self-checking bench for cla_pg_pipe_stage: directed table, backpressure and
// reset sequences, and random streaming against a queue-based reference model.
module tb_cla_pg_pipe_stage;

    localparam int WIDTH = 32;
    localparam int NG    = WIDTH / 4;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             in_valid_i;
    logic             in_ready_o;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             cin_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [WIDTH-1:0] propagate_o;
    logic [WIDTH-1:0] generate_o;
    logic [NG-1:0]    group_propagate_o;
    logic [NG-1:0]    group_generate_o;
    logic             cin_o;

    cla_pg_pipe_stage #(.WIDTH(WIDTH)) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .in_valid_i        (in_valid_i),
        .in_ready_o        (in_ready_o),
        .a_i               (a_i),
        .b_i               (b_i),
        .cin_i             (cin_i),
        .out_valid_o       (out_valid_o),
        .out_ready_i       (out_ready_i),
        .propagate_o       (propagate_o),
        .generate_o        (generate_o),
        .group_propagate_o (group_propagate_o),
        .group_generate_o  (group_generate_o),
        .cin_o             (cin_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [WIDTH-1:0] p;
        logic [WIDTH-1:0] g;
        logic [NG-1:0]    gp;
        logic [NG-1:0]    gg;
        logic             cin;
    } pg_t;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
        logic [WIDTH-1:0] p;
        logic [WIDTH-1:0] g;
        logic [NG-1:0]    gp;
        logic [NG-1:0]    gg;
    } vec_t;

    pg_t exp_q[$];
    int  passed = 0;
    int  total  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        else
            passed++;
    endtask

    // Group P/G from nibble sums: a sum of exactly 15 passes any carry-in, >= 16 makes one.
    function automatic pg_t ref_pg(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic cin);
        pg_t r;
        r.p   = a ^ b;
        r.g   = a & b;
        r.cin = cin;
        for (int k = 0; k < NG; k++) begin
            int unsigned sum;
            sum = ((a >> (4 * k)) & 32'hF) + ((b >> (4 * k)) & 32'hF);
            r.gp[k] = (sum == 15);
            r.gg[k] = (sum >= 16);
        end
        return r;
    endfunction

    // One clock: check the DUT against the model, then advance the model over the edge.
    task automatic cycle(output bit acc);
        bit  del;
        pg_t e;
        acc = 1'b0;
        del = 1'b0;
        check("in_ready", in_ready_o, exp_q.size() < 2);
        check("out_valid", out_valid_o, exp_q.size() > 0);
        if (exp_q.size() > 0) begin
            e = exp_q[0];
            check("propagate", propagate_o, e.p);
            check("generate", generate_o, e.g);
            check("group_propagate", group_propagate_o, e.gp);
            check("group_generate", group_generate_o, e.gg);
            check("cin_o", cin_o, e.cin);
        end
        if (!rst_i) begin
            acc = in_valid_i && (exp_q.size() < 2);
            del = out_ready_i && (exp_q.size() > 0);
        end
        @(posedge clk_i);
        if (rst_i) begin
            exp_q.delete();
        end else begin
            if (del) void'(exp_q.pop_front());
            if (acc) exp_q.push_back(ref_pg(a_i, b_i, cin_i));
        end
        @(negedge clk_i);
    endtask

    task automatic drive_word(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c);
        in_valid_i = 1'b1;
        a_i        = a;
        b_i        = b;
        cin_i      = c;
    endtask

    vec_t vecs[6];

    initial begin
        bit acc;
        int sent;

        vecs[0] = '{a: 32'h0000_000F, b: 32'h0000_0001, cin: 1'b0,
                    p: 32'h0000_000E, g: 32'h0000_0001, gp: 8'h00, gg: 8'h01};
        vecs[1] = '{a: 32'hFFFF_FFFF, b: 32'h0000_0000, cin: 1'b1,
                    p: 32'hFFFF_FFFF, g: 32'h0000_0000, gp: 8'hFF, gg: 8'h00};
        vecs[2] = '{a: 32'h8888_8888, b: 32'h8888_8888, cin: 1'b0,
                    p: 32'h0000_0000, g: 32'h8888_8888, gp: 8'h00, gg: 8'hFF};
        vecs[3] = '{a: 32'h0000_FFFF, b: 32'h0000_FFFF, cin: 1'b1,
                    p: 32'h0000_0000, g: 32'h0000_FFFF, gp: 8'h00, gg: 8'h0F};
        vecs[4] = '{a: 32'h0000_00A5, b: 32'h0000_005A, cin: 1'b0,
                    p: 32'h0000_00FF, g: 32'h0000_0000, gp: 8'h03, gg: 8'h00};
        vecs[5] = '{a: 32'h0000_0003, b: 32'h0000_000D, cin: 1'b1,
                    p: 32'h0000_000E, g: 32'h0000_0001, gp: 8'h00, gg: 8'h01};

        // Reset for two cycles with a word offered; it must be discarded.
        rst_i       = 1'b1;
        out_ready_i = 1'b1;
        drive_word(32'h1234_5678, 32'h0F0F_0F0F, 1'b1);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_i      = 1'b0;
        in_valid_i = 1'b0;
        check("reset_out_valid", out_valid_o, 1'b0);
        check("reset_in_ready", in_ready_o, 1'b1);
        check("reset_propagate", propagate_o, '0);
        check("reset_generate", generate_o, '0);
        check("reset_group_propagate", group_propagate_o, '0);
        check("reset_group_generate", group_generate_o, '0);
        check("reset_cin_o", cin_o, 1'b0);

        // Directed table, one isolated word at a time.
        foreach (vecs[i]) begin
            drive_word(vecs[i].a, vecs[i].b, vecs[i].cin);
            cycle(acc);
            in_valid_i = 1'b0;
            check("vec_out_valid", out_valid_o, 1'b1);
            check("vec_propagate", propagate_o, vecs[i].p);
            check("vec_generate", generate_o, vecs[i].g);
            check("vec_group_propagate", group_propagate_o, vecs[i].gp);
            check("vec_group_generate", group_generate_o, vecs[i].gg);
            check("vec_cin_o", cin_o, vecs[i].cin);
            cycle(acc);
        end

        // Backpressure: three back-to-back words into a stalled stage.
        out_ready_i = 1'b0;
        drive_word(32'hAAAA_0001, 32'h5555_0002, 1'b0);
        cycle(acc);
        drive_word(32'hAAAA_0003, 32'h5555_0004, 1'b1);
        cycle(acc);
        check("bp_in_ready_after_w1", in_ready_o, 1'b0);
        drive_word(32'hAAAA_0005, 32'h5555_0006, 1'b0);
        acc = 1'b0;
        for (int c = 0; c < 3; c++) cycle(acc);
        check("bp_w2_held", acc, 1'b0);
        out_ready_i = 1'b1;
        acc = 1'b0;
        for (int c = 0; c < 5 && !acc; c++) cycle(acc);
        check("bp_w2_accepted", acc, 1'b1);
        in_valid_i = 1'b0;
        for (int c = 0; c < 5 && exp_q.size() > 0; c++) cycle(acc);
        check("bp_drained", out_valid_o, 1'b0);

        // Random streaming with random backpressure.
        sent = 0;
        acc  = 1'b1;
        for (int c = 0; c < 20000 && sent < 1000; c++) begin
            if (!(in_valid_i && !acc)) begin
                in_valid_i = ($urandom_range(0, 3) != 0);
                a_i        = $urandom;
                b_i        = $urandom;
                cin_i      = $urandom_range(0, 1);
            end
            out_ready_i = $urandom_range(0, 1);
            cycle(acc);
            if (acc) sent++;
        end
        check("stream_sent", sent, 1000);
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        for (int c = 0; c < 5 && exp_q.size() > 0; c++) cycle(acc);
        check("stream_drained", out_valid_o, 1'b0);

        // Full-rate streaming: ready never drops while downstream always accepts.
        for (int c = 0; c < 200; c++) begin
            in_valid_i = ($urandom_range(0, 4) != 0);
            a_i        = $urandom;
            b_i        = $urandom;
            cin_i      = $urandom_range(0, 1);
            check("stream_in_ready_high", in_ready_o, 1'b1);
            cycle(acc);
        end
        in_valid_i = 1'b0;
        cycle(acc);

        // Reset while holding two words: neither may ever appear.
        out_ready_i = 1'b0;
        drive_word(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1);
        cycle(acc);
        drive_word(32'hCAFE_0000, 32'h0000_CAFE, 1'b0);
        cycle(acc);
        check("two_in_ready_low", in_ready_o, 1'b0);
        rst_i       = 1'b1;
        out_ready_i = 1'b1;
        drive_word(32'h1111_1111, 32'h2222_2222, 1'b1);
        cycle(acc);
        rst_i      = 1'b0;
        in_valid_i = 1'b0;
        check("rst_two_out_valid", out_valid_o, 1'b0);
        check("rst_two_in_ready", in_ready_o, 1'b1);
        check("rst_two_propagate", propagate_o, '0);
        for (int c = 0; c < 3; c++) cycle(acc);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
